// File: rtl/aes_round_sched_if.sv
// Request/response/engine bundle for aes_round_sched. The slave side is the
// sequencer; the master side is the requesters, the consumer and the round engine.
interface aes_round_sched_if;
  logic         req0_valid;
  logic         req0_ready;
  logic [127:0] req0_key;
  logic         req1_valid;
  logic         req1_ready;
  logic [127:0] req1_key;
  logic         eng_start;
  logic [127:0] eng_state;
  logic [127:0] eng_key;
  logic [127:0] eng_result;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_id;
  logic         busy;

  modport slave (
    input  req0_valid, req0_key, req1_valid, req1_key, eng_result, rsp_ready,
    output req0_ready, req1_ready, eng_start, eng_state, eng_key,
           rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req0_valid, req0_key, req1_valid, req1_key, eng_result, rsp_ready,
    input  req0_ready, req1_ready, eng_start, eng_state, eng_key,
           rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/aes_round_sched.sv
// Iterative sequencer sharing one external AES round engine between two requesters.
// Define AES_SCHED_ABORT_EN to add an 'abort' input that cancels an in-flight operation.
module aes_round_sched #(
  parameter int unsigned  NUM_ROUNDS = 5,
  parameter int unsigned  ROUND_LAT  = 1,
  parameter logic [127:0] SEED       = 128'hc2f45dfa_8acd3f4d_a3dcfe8a_93cefa0a
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef AES_SCHED_ABORT_EN
  input  logic              abort,
`endif
  aes_round_sched_if.slave  bus
);
  localparam int unsigned LW = $clog2(ROUND_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [127:0]   d_q, d_d;
  logic           rsp_id_q, rsp_id_d;
  logic           last_grant_q, last_grant_d;
  logic [3:0]     round_cnt_q, round_cnt_d;
  logic [LW-1:0]  lat_cnt_q, lat_cnt_d;
  logic           gnt_vld, gnt_id;
  logic           abort_w;

`ifdef AES_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Round-robin: a tie goes to the requester that was not served last.
  always_comb begin
    gnt_vld = bus.req0_valid | bus.req1_valid;
    gnt_id  = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
  end

  assign bus.req0_ready = (state_q == IDLE) & gnt_vld & ~gnt_id;
  assign bus.req1_ready = (state_q == IDLE) & gnt_vld &  gnt_id;
  assign bus.eng_start  = (state_q == ISSUE) & ~abort_w;
  assign bus.eng_state  = SEED;
  assign bus.eng_key    = d_q;
  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.rsp_data   = d_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.busy       = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    d_d          = d_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    round_cnt_d  = round_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          d_d          = (gnt_id ? bus.req1_key : bus.req0_key) ^ SEED;
          rsp_id_d     = gnt_id;
          last_grant_d = gnt_id;
          round_cnt_d  = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (abort_w) begin
          d_d     = '0;
          state_d = IDLE;
        end else begin
          lat_cnt_d = LW'(1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (abort_w) begin
          d_d     = '0;
          state_d = IDLE;
        end else if (lat_cnt_q == LW'(ROUND_LAT)) begin
          d_d = bus.eng_result;
          if (round_cnt_q == 4'(NUM_ROUNDS - 1)) begin
            state_d = DONE;
          end else begin
            round_cnt_d = round_cnt_q + 4'd1;
            state_d     = ISSUE;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      d_q          <= '0;
      rsp_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      round_cnt_q  <= '0;
      lat_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      d_q          <= d_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
      round_cnt_q  <= round_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
    end
  end
endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched: default build (5 rounds, latency 1) plus a
// 2-round / latency-3 instance, both driven by an XOR engine stub.
module tb_aes_round_sched;
  localparam logic [127:0] SEED = 128'hc2f45dfa_8acd3f4d_a3dcfe8a_93cefa0a;
  localparam logic [127:0] K0   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] K1   = 128'hdeadbeef_01234567_89abcdef_fedcba98;

  logic clk = 1'b0;
  logic rst_n;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 clk = ~clk;

  aes_round_sched_if ifa ();
  aes_round_sched_if ifb ();

  assign ifa.eng_result = ifa.eng_state ^ ifa.eng_key;
  assign ifb.eng_result = ifb.eng_state ^ ifb.eng_key;

`ifdef AES_SCHED_ABORT_EN
  logic abort_a;
  logic abort_b;
`endif

  aes_round_sched dut_a (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef AES_SCHED_ABORT_EN
    .abort (abort_a),
`endif
    .bus   (ifa)
  );

  aes_round_sched #(.NUM_ROUNDS(2), .ROUND_LAT(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef AES_SCHED_ABORT_EN
    .abort (abort_b),
`endif
    .bus   (ifb)
  );

  typedef struct {
    logic [127:0] key;
    bit           id;
    logic [127:0] exp_data;
    int           exp_lat;
    logic [15:0]  exp_smask;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issues one request on dut_a starting just after a rising edge (cycle 0) and
  // runs it to the response handshake (rsp_ready assumed high).
  task automatic run_a(input logic [127:0] k, input bit id, output bit acc, output int lat,
                       output logic [15:0] sm, output logic [127:0] data, output bit rid);
    sm = '0; lat = -1; acc = 1'b0; data = '0; rid = 1'b0;
    if (id) begin ifa.req1_valid = 1'b1; ifa.req1_key = k; end
    else    begin ifa.req0_valid = 1'b1; ifa.req0_key = k; end
    @(negedge clk);
    acc = id ? ifa.req1_ready : ifa.req0_ready;
    @(posedge clk); #1;
    ifa.req0_valid = 1'b0;
    ifa.req1_valid = 1'b0;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (ifa.eng_start && c < 16) sm[c] = 1'b1;
      if (ifa.rsp_valid) begin
        lat = c; data = ifa.rsp_data; rid = ifa.rsp_id;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  // Waits (bounded) for a response on dut_a, checks it, and lets the handshake happen.
  task automatic wait_rsp_a(input string nm, input logic [127:0] exp_d, input bit exp_id);
    bit got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ifa.rsp_valid) begin got = 1'b1; break; end
    end
    chki({nm, "_seen"}, int'(got), 1);
    chk({nm, "_data"}, ifa.rsp_data, exp_d);
    chki({nm, "_id"}, int'(ifa.rsp_id), int'(exp_id));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t         vt[4];
    bit           acc, rid;
    int           lat;
    logic [15:0]  sm;
    logic [127:0] data;

    vt[0] = '{K0,                                       1'b0, K0,                                       11, 16'h02AA};
    vt[1] = '{K1,                                       1'b1, K1,                                       11, 16'h02AA};
    vt[2] = '{128'h0,                                   1'b0, 128'h0,                                   11, 16'h02AA};
    vt[3] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 1'b1, 128'hffffffff_ffffffff_ffffffff_ffffffff, 11, 16'h02AA};

    rst_n = 1'b0;
    ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0; ifa.req0_key = '0; ifa.req1_key = '0;
    ifa.rsp_ready  = 1'b1;
    ifb.req0_valid = 1'b0; ifb.req1_valid = 1'b0; ifb.req0_key = '0; ifb.req1_key = '0;
    ifb.rsp_ready  = 1'b1;
`ifdef AES_SCHED_ABORT_EN
    abort_a = 1'b0;
    abort_b = 1'b0;
`endif

    // Reset state
    #12;
    chki("rst_ctrl", int'({ifa.busy, ifa.rsp_valid, ifa.eng_start, ifa.rsp_id}), 0);
    chk("rst_rsp_data", ifa.rsp_data, '0);
    chk("rst_eng_key", ifa.eng_key, '0);
    chk("rst_eng_state", ifa.eng_state, SEED);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-request table
    foreach (vt[i]) begin
      run_a(vt[i].key, vt[i].id, acc, lat, sm, data, rid);
      chki($sformatf("vec%0d_accept", i), int'(acc), 1);
      chki($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
      chki($sformatf("vec%0d_start_mask", i), int'(sm), int'(vt[i].exp_smask));
      chk($sformatf("vec%0d_data", i), data, vt[i].exp_data);
      chki($sformatf("vec%0d_id", i), int'(rid), int'(vt[i].id));
    end

    // Backpressure: response held 20 cycles, then a waiting req1 accepted after handshake
    begin
      bit got = 1'b0;
      ifa.rsp_ready  = 1'b0;
      ifa.req0_valid = 1'b1; ifa.req0_key = K0;
      @(posedge clk); #1;
      ifa.req0_valid = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (ifa.rsp_valid) begin got = 1'b1; break; end
      end
      chki("bp_reached", int'(got), 1);
      @(posedge clk); #1;
      ifa.req1_valid = 1'b1; ifa.req1_key = K1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chki("bp_hold_valid", int'(ifa.rsp_valid), 1);
        chk("bp_hold_data", ifa.rsp_data, K0);
        chki("bp_hold_readies", int'({ifa.req0_ready, ifa.req1_ready}), 0);
        @(posedge clk); #1;
      end
      ifa.rsp_ready = 1'b1;
      @(negedge clk);
      chki("bp_hs_valid", int'(ifa.rsp_valid), 1);
      chki("bp_hs_no_accept", int'(ifa.req1_ready), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chki("bp_next_accept", int'(ifa.req1_ready), 1);
      chki("bp_next_idle", int'(ifa.busy), 0);
      @(posedge clk); #1;
      ifa.req1_valid = 1'b0;
      wait_rsp_a("bp_follow", K1, 1'b1);
    end

    // Asynchronous reset during the WAIT of the third round (cycle 6)
    begin
      bit seen = 1'b0;
      ifa.req0_valid = 1'b1; ifa.req0_key = K0;
      @(posedge clk); #1;
      ifa.req0_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chki("mid_busy", int'({ifa.busy, ifa.eng_start}), 2);
      #2 rst_n = 1'b0;
      #1;
      chki("mid_rst_ctrl", int'({ifa.busy, ifa.rsp_valid, ifa.eng_start, ifa.rsp_id,
                                 ifa.req0_ready, ifa.req1_ready}), 0);
      chk("mid_rst_data", ifa.rsp_data, '0);
      chk("mid_rst_key", ifa.eng_key, '0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        seen = seen | ifa.busy | ifa.rsp_valid;
      end
      chki("post_rst_quiet", int'(seen), 0);
      @(posedge clk); #1;
    end

    // Fairness: both requesters continuously valid, starting from reset last_grant
    begin
      int           n = 0;
      bit           ids[4];
      logic [127:0] dat[4];
      ifa.req0_valid = 1'b1; ifa.req0_key = K0;
      ifa.req1_valid = 1'b1; ifa.req1_key = K1;
      for (int c = 0; c < 200 && n < 4; c++) begin
        @(negedge clk);
        if (ifa.rsp_valid) begin
          ids[n] = ifa.rsp_id; dat[n] = ifa.rsp_data; n++;
        end
        @(posedge clk); #1;
      end
      ifa.req0_valid = 1'b0;
      ifa.req1_valid = 1'b0;
      chki("rr_count", n, 4);
      for (int i = 0; i < 4; i++) begin
        chki($sformatf("rr%0d_id", i), int'(ids[i]), i % 2);
        chk($sformatf("rr%0d_data", i), dat[i], (i % 2 == 1) ? K1 : K0);
      end
    end

    // NUM_ROUNDS=2, ROUND_LAT=3 instance
    begin
      logic [15:0] smb = '0;
      int          latb = -1;
      ifb.req0_valid = 1'b1; ifb.req0_key = K0;
      @(negedge clk);
      chki("b_accept", int'(ifb.req0_ready), 1);
      @(posedge clk); #1;
      ifb.req0_valid = 1'b0;
      for (int c = 1; c < 30; c++) begin
        @(negedge clk);
        if (ifb.eng_start && c < 16) smb[c] = 1'b1;
        if (ifb.rsp_valid) begin latb = c; break; end
        @(posedge clk); #1;
      end
      chki("b_start_mask", int'(smb), int'(16'h0022));
      chki("b_latency", latb, 9);
      chk("b_data", ifb.rsp_data, 128'hc2e57fc9_ce98593a_2b455431_5f1314f5);
      chki("b_id", int'(ifb.rsp_id), 0);
      @(posedge clk); #1;
    end

`ifdef AES_SCHED_ABORT_EN
    // Abort in cycle 4 (WAIT), then a req1 in cycle 5 is accepted
    ifa.req0_valid = 1'b1; ifa.req0_key = K0;
    @(posedge clk); #1;
    ifa.req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    chki("abort_idle", int'({ifa.busy, ifa.rsp_valid}), 0);
    chk("abort_d_cleared", ifa.rsp_data, '0);
    ifa.req1_valid = 1'b1; ifa.req1_key = K1;
    @(negedge clk);
    chki("abort_next_accept", int'(ifa.req1_ready), 1);
    @(posedge clk); #1;
    ifa.req1_valid = 1'b0;
    wait_rsp_a("abort_follow", K1, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
